// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - default sizing constants and address-width helper for reg_file_np
package reg_file_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NRD   = 2;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/decoder_en.sv
// rtl/decoder_en.sv - AW-to-DEPTH one-hot decoder with enable, purely combinational
module decoder_en
    import reg_file_pkg::*;
#(
    parameter int AW    = addr_width(DEF_DEPTH),
    parameter int DEPTH = 1 << AW
) (
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    output logic [DEPTH-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_np.sv
// rtl/reg_file_np.sv - DEPTH x WIDTH register file, one write port, NRD registered read ports
// with write-to-read bypass and optional hardwired-zero register 0.
module reg_file_np
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NRD      = DEF_NRD,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid
);

    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0]     wr_line;
    logic [WIDTH-1:0]     rd_data_d [NRD];
    logic [NRD*WIDTH-1:0] rd_data_q;
    logic [NRD-1:0]       rd_valid_q;

    decoder_en #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_dec (
        .en_i   (wr_en),
        .addr_i (wr_addr),
        .dec_o  (wr_line)
    );

    // Register 0 never takes a write when hardwired, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst) begin
                regs_q[k] <= '0;
            end else if (wr_line[k] && !(ZERO_REG && (k == 0))) begin
                regs_q[k] <= wr_data;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];

        // A same-cycle write to the read address forwards wr_data, except to the zero register.
        always_comb begin
            rd_data_d[i] = regs_q[addr];
            if (ZERO_REG && (addr == '0)) begin
                rd_data_d[i] = '0;
            end else if (wr_en && (wr_addr == addr)) begin
                rd_data_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= rd_en;
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    rd_data_q[i*WIDTH +: WIDTH] <= rd_data_d[i];
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_np.sv
// tb/tb_reg_file_np.sv - self-checking bench for reg_file_np: directed scenarios plus
// randomized traffic compared against a behavioural register-file model.
module tb_reg_file_np;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int N  = 2;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [W-1:0]   wr_data;
    logic [N-1:0]   rd_en;
    logic [N*AW-1:0] rd_addr;
    logic [N*W-1:0] rd_data;
    logic [N-1:0]   rd_valid;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mem [D];
    logic [W-1:0] exp_d [N];
    logic [N-1:0] exp_v;

    reg_file_np #(
        .WIDTH    (W),
        .DEPTH    (D),
        .NRD      (N),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: reads see the array before this edge's write, with write forwarding except to r0.
    task automatic tick(input string tag);
        logic [W-1:0] nd [N];
        int a;
        if (rst) begin
            for (int k = 0; k < D; k++) mem[k] = '0;
            for (int p = 0; p < N; p++) nd[p] = '0;
            exp_v = '0;
        end else begin
            for (int p = 0; p < N; p++) begin
                a = int'(rd_addr[p*AW +: AW]);
                if (!rd_en[p])                             nd[p] = exp_d[p];
                else if (a == 0)                           nd[p] = '0;
                else if (wr_en && (int'(wr_addr) == a))    nd[p] = wr_data;
                else                                       nd[p] = mem[a];
            end
            exp_v = rd_en;
            if (wr_en && (wr_addr != 0)) mem[wr_addr] = wr_data;
        end
        for (int p = 0; p < N; p++) exp_d[p] = nd[p];
        @(posedge clk);
        #1;
        check({tag, ".d0"}, rd_data[0 +: W], exp_d[0]);
        check({tag, ".d1"}, rd_data[W +: W], exp_d[1]);
        check({tag, ".v"}, W'(rd_valid), W'(exp_v));
    endtask

    task automatic set_wr(input logic en, input int addr, input logic [W-1:0] data);
        wr_en   = en;
        wr_addr = AW'(addr);
        wr_data = data;
    endtask

    task automatic set_rd(input logic [N-1:0] en, input int a0, input int a1);
        rd_en   = en;
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        for (int k = 0; k < D; k++) mem[k] = '0;
        for (int p = 0; p < N; p++) exp_d[p] = '0;
        exp_v = '0;
        rst = 1'b1;
        set_wr(1'b0, 0, '0);
        set_rd(2'b00, 0, 0);

        tick("reset");
        check("reset.d", rd_data[31:0], 32'h0);
        check("reset.v", W'(rd_valid), 32'h0);
        rst = 1'b0;

        // Reset clears a written register and suppresses the in-flight read.
        set_wr(1'b1, 5, 32'hDEADBEEF);
        tick("rst_wr");
        set_wr(1'b0, 0, '0);
        rst = 1'b1;
        set_rd(2'b01, 5, 0);
        tick("rst_mid");
        check("rst_mid.v0", W'(rd_valid[0]), 32'h0);
        rst = 1'b0;
        tick("rst_rd");
        check("rst_rd.d0", rd_data[31:0], 32'h0);
        check("rst_rd.v0", W'(rd_valid[0]), 32'h1);

        // Plain write then read on port 1.
        set_rd(2'b00, 0, 0);
        set_wr(1'b1, 7, 32'h12345678);
        tick("wr7");
        set_wr(1'b0, 0, '0);
        set_rd(2'b10, 0, 7);
        tick("rd7");
        check("rd7.d1", rd_data[63:32], 32'h12345678);
        check("rd7.v1", W'(rd_valid[1]), 32'h1);

        // Bypass of a same-cycle write.
        set_rd(2'b00, 0, 0);
        set_wr(1'b1, 3, 32'h1);
        tick("wr3");
        set_wr(1'b1, 3, 32'hA5A5A5A5);
        set_rd(2'b01, 3, 0);
        tick("byp3");
        check("byp3.d0", rd_data[31:0], 32'hA5A5A5A5);

        // Zero register ignores writes and never bypasses.
        set_wr(1'b1, 0, 32'hFFFFFFFF);
        set_rd(2'b11, 0, 0);
        tick("zero");
        check("zero.d0", rd_data[31:0], 32'h0);
        check("zero.d1", rd_data[63:32], 32'h0);

        // Decoder sweep: every index gets a distinct value, then all are read back.
        set_rd(2'b00, 0, 0);
        for (int k = 0; k < D; k++) begin
            set_wr(1'b1, k, W'(k + 1));
            tick("sweep_wr");
        end
        set_wr(1'b0, 0, '0);
        for (int k = 0; k < D; k++) begin
            set_rd(2'b11, k, D - 1 - k);
            tick("sweep_rd");
            check("sweep.d0", rd_data[31:0], (k == 0) ? 32'h0 : W'(k + 1));
            check("sweep.d1", rd_data[63:32], (k == D - 1) ? 32'h0 : W'(D - k));
        end

        // Hold: port 0 keeps its last value while disabled.
        set_rd(2'b00, 0, 0);
        set_wr(1'b1, 9, 32'h99);
        tick("wr9");
        set_wr(1'b0, 0, '0);
        set_rd(2'b01, 9, 0);
        tick("rd9");
        check("rd9.d0", rd_data[31:0], 32'h99);
        set_rd(2'b00, 0, 0);
        for (int c = 0; c < 3; c++) begin
            tick("hold");
            check("hold.d0", rd_data[31:0], 32'h99);
            check("hold.v0", W'(rd_valid[0]), 32'h0);
        end

        // Randomized traffic with occasional resets; addresses biased to collide.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_wr(1'(($urandom() & 32'h3) != 0), int'($urandom_range(0, 7)), $urandom());
            set_rd(N'($urandom()), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            tick("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_np.md
REG_FILE_NP -- requirements
Module: reg_file_np

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, register count; power of two, at least 2.
REQ-003 Parameter NRD, default 2, number of read ports, 1 to 4.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero and ignores writes.
REQ-005 Derived constant AW = clog2(DEPTH), address width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 wr_en  input  1  write request this cycle.
REQ-009 wr_addr  input  AW  write register index.
REQ-010 wr_data  input  WIDTH  write data.
REQ-011 rd_en  input  NRD  per-port read request.
REQ-012 rd_addr  input  NRD*AW  packed read indices; port i occupies bits [i*AW +: AW].
REQ-013 rd_data  output  NRD*WIDTH  packed read data, registered; port i occupies bits [i*WIDTH +: WIDTH].
REQ-014 rd_valid  output  NRD  per-port flag: rd_data slice updated by the previous cycle's read.

Function
REQ-015 Write decode SHALL be one-hot over DEPTH lines: exactly one line high when wr_en=1, all lines low when wr_en=0; no line holds a stale value from a prior cycle.
REQ-016 A write SHALL commit wr_data to register wr_addr at the rising edge where wr_en=1 and rst=0.
REQ-017 With ZERO_REG=1, a write to address 0 SHALL be discarded; register 0 always reads 0.
REQ-018 Reads SHALL have 1-cycle latency: rd_data port i at edge N+1 reflects rd_addr port i sampled at edge N with rd_en[i]=1.
REQ-019 Same-cycle write/read to the same writable address SHALL bypass: rd_data returns the new wr_data, not the old contents.
REQ-020 Bypass SHALL NOT apply to address 0 when ZERO_REG=1; the read returns 0.
REQ-021 When rd_en[i]=0, rd_data port i SHALL hold its previous value and rd_valid[i] SHALL be 0 on the next cycle.
REQ-022 rd_valid[i] SHALL equal rd_en[i] registered by one cycle.
REQ-023 All NRD ports SHALL operate independently; identical addresses on several ports return identical data.
REQ-024 All wr_addr and rd_addr values are in range because DEPTH is a power of two; there SHALL be no error path.

Reset
REQ-025 On rst=1 at a rising edge, every register, every rd_data slice and every rd_valid bit SHALL become 0.
REQ-026 rst SHALL take priority over a simultaneous write or read; neither takes effect in that cycle.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight read; rd_valid=0 on the cycle after reset.
REQ-028 Normal operation SHALL resume at the first edge with rst=0.

Structure
REQ-029 Package reg_file_pkg SHALL hold the default WIDTH, DEPTH and NRD constants and the AW derivation function.
REQ-030 Sub-module decoder_en SHALL implement the parametrised AW-to-DEPTH one-hot decoder with enable; it is purely combinational and has every output assigned on every path.
REQ-031 Storage SHALL be a DEPTH x WIDTH register array in reg_file_np; read muxing and bypass stay in reg_file_np.

Verification
REQ-032 Reset: write 0xDEADBEEF to r5, assert rst one cycle, read r5 on port 0 -> rd_data[0]=0, and rd_valid=0 during the reset cycle.
REQ-033 Write/read: write 0x12345678 to r7, read r7 next cycle on port 1 -> rd_data[1]=0x12345678 with rd_valid[1]=1 one cycle after the read.
REQ-034 Bypass: r3 holds 0x1, same cycle write 0xA5A5A5A5 to r3 and read r3 on port 0 -> rd_data[0]=0xA5A5A5A5.
REQ-035 Zero register: write 0xFFFFFFFF to r0 while reading r0 on both ports -> both ports return 0.
REQ-036 Decoder sweep: write value (index+1) to every index 0..31, then read all 32 back -> r0=0, r_k=k+1, and no register overwritten by a neighbour's write.
REQ-037 Hold: read r9 (0x99), then deassert rd_en[0] for 3 cycles -> rd_data[0] stays 0x99 and rd_valid[0]=0 throughout.
